// File: rtl/btn_pulse_gen_pkg.sv
// Shared state encoding and default parameters for the button pulse generator.
// No logic; imported by btn_pulse_gen and its bench.
// Values here are the defaults used when the top is instantiated without overrides.
package btn_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 8;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;

endpackage

// File: rtl/btn_pulse_gen_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk edges from d to q.
// Backpressure: none; q simply follows d.
module btn_pulse_gen_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounces a raw button into a one-cycle count pulse plus a clean level; BTN_PULSE_GEN_AUTO_REPEAT_EN adds hold-to-repeat.
// Latency: pulse/level rise DEBOUNCE_CYCLES+3 edges after btn_in is first sampled high; level falls likewise on release.
// Backpressure: none; pulse is a fire-and-forget strobe for the downstream counter.
module btn_pulse_gen
    import btn_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             pulse_d, level_d;
    logic             s2;

    btn_pulse_gen_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s2)
    );

`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
    // After each repeat the counter is rewound so the next one lands
    // REPEAT_PERIOD cycles later; this needs REPEAT_PERIOD <= REPEAT_DELAY.
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) rep_cnt_q <= '0;
        else        rep_cnt_q <= rep_cnt_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
            pulse     <= 1'b0;
            level     <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            pulse     <= pulse_d;
            level     <= level_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        pulse_d   = 1'b0;
        level_d   = level;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
        // Zero outside HELD, so the delay restarts on every HELD entry.
        rep_cnt_d = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s2) begin
                    state_d   = ST_PRESS_CHK;
                    deb_cnt_d = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!s2) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!s2) begin
                    state_d   = ST_REL_CHK;
                    deb_cnt_d = '0;
                end
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
                else if (rep_cnt_q == REP_LAST) begin
                    pulse_d   = 1'b1;
                    rep_cnt_d = REP_RELOAD;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
`endif
            end
            ST_REL_CHK: begin
                if (s2) begin
                    state_d = ST_HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed vector table, boundary sequences and
// randomized bouncing input against a run-length reference model.
module tb_btn_pulse_gen;

    localparam int D        = 4;
    localparam int R_DELAY  = 8;
    localparam int R_PERIOD = 4;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic pulse;
    logic level;

    always #5 clk = ~clk;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (R_DELAY),
        .REPEAT_PERIOD   (R_PERIOD)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .pulse  (pulse),
        .level  (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Repeat pulse due after `age` cycles of continuous holding.
    function automatic bit rep_hit(input int age);
        return REP_EN && ((age == R_DELAY) ||
               (age > R_DELAY && ((age - R_DELAY) % R_PERIOD) == 0));
    endfunction

    // Reference: the FSM sees btn_in two edges late; the level flips once the
    // opposite value has been seen on D+1 consecutive edges.
    bit m_s1, m_s2, m_level, m_pulse;
    int m_run, m_age;

    task automatic model_edge(input logic r, input logic b);
        bit seen;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0; m_age = 0;
            return;
        end
        seen    = m_s2;
        m_s2    = m_s1;
        m_s1    = b;
        m_pulse = 0;
        if (seen != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = seen;
                m_run   = 0;
                m_age   = 0;
                m_pulse = seen;
            end
        end else if (m_level && m_run == 0) begin
            m_age++;
            m_pulse = rep_hit(m_age);
        end else begin
            m_run = 0;
            m_age = 0;
        end
    endtask

    task automatic step(input logic r, input logic b);
        reset  = r;
        btn_in = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
    endtask

    typedef struct {
        logic rst_n;
        logic btn;
        logic exp_pulse;
        logic exp_level;
    } vec_t;

    vec_t tab[$];

    function automatic void add(input logic r, input logic b, input logic p, input logic l);
        vec_t v;
        v.rst_n = r; v.btn = b; v.exp_pulse = p; v.exp_level = l;
        tab.push_back(v);
    endfunction

    initial begin
        int  cnt;
        bit  saw;
        int  pe[$];
        int  seg_len;
        logic seg_val;

        reset  = 1'b0;
        btn_in = 1'b0;

        // reset held with button pressed, then a clean 20-cycle press and release
        repeat (3) add(0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) add(1, 1, (k == 7) || (k > 7 && rep_hit(k - 7)), k >= 7);
        for (int j = 1; j <= 12; j++) add(1, 0, (j <= 2) && rep_hit(13 + j), j < 7);
        // press bounce rejected
        add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0);
        repeat (8) add(1, 0, 0, 0);
        // release bounce while held
        for (int k = 1; k <= 10; k++) add(1, 1, k == 7, k >= 7);
        repeat (2) add(1, 0, 0, 1);
        repeat (8) add(1, 1, 0, 1);
        for (int j = 1; j <= 8; j++) add(1, 0, 0, j < 7);
        // reset during PRESS_CHK, then a fresh press
        repeat (4) add(1, 1, 0, 0);
        add(0, 1, 0, 0);
        repeat (6) add(1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) add(1, 1, k == 7, k >= 7);
        for (int j = 1; j <= 8; j++) add(1, 0, 0, j < 7);

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].rst_n, tab[i].btn);
            check($sformatf("vec%0d.pulse", i), pulse, tab[i].exp_pulse);
            check($sformatf("vec%0d.level", i), level, tab[i].exp_level);
        end

        // press exactly D cycles long is one sample short of acceptance
        cnt = 0; saw = 0;
        repeat (D)  begin step(1, 1); cnt += int'(pulse); saw |= level; end
        repeat (10) begin step(1, 0); cnt += int'(pulse); saw |= level; end
        check_int("short_press.pulses", cnt, 0);
        check("short_press.level", saw, 1'b0);

        // press of D+1 cycles is the shortest accepted
        cnt = 0; saw = 0;
        repeat (D + 1) begin step(1, 1); cnt += int'(pulse); saw |= level; end
        repeat (12)    begin step(1, 0); cnt += int'(pulse); saw |= level; end
        check_int("min_press.pulses", cnt, 1);
        check("min_press.level_rose", saw, 1'b1);
        check("min_press.level_end", level, 1'b0);

        // release gap of D cycles does not release
        cnt = 0; saw = 0;
        repeat (10) begin step(1, 1); cnt += int'(pulse); end
        repeat (D)  begin step(1, 0); cnt += int'(pulse); saw |= !level; end
        repeat (6)  begin step(1, 1); cnt += int'(pulse); saw |= !level; end
        check("rel_glitch.level_dropped", saw, 1'b0);
        repeat (12) begin step(1, 0); cnt += int'(pulse); end
        check_int("rel_glitch.pulses", cnt, 1);
        check("rel_glitch.level_end", level, 1'b0);

`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
        // 30-cycle hold with auto-repeat
        for (int e = 1; e <= 40; e++) begin
            step(1, e <= 30);
            if (pulse) pe.push_back(e);
        end
        check_int("repeat.count", pe.size(), 6);
        begin
            int exp_e[6] = '{7, 15, 19, 23, 27, 31};
            for (int i = 0; i < 6 && i < pe.size(); i++)
                check_int($sformatf("repeat.edge%0d", i), pe[i], exp_e[i]);
        end
`endif

        // randomized bouncing input with occasional reset
        step(0, 0);
        for (int c = 0; c < 3000; ) begin
            seg_val = 1'($urandom_range(0, 1));
            seg_len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, D + 1)
                                                   : $urandom_range(D + 2, 40);
            for (int k = 0; k < seg_len; k++) begin
                step(($urandom_range(0, 199) != 0), seg_val);
                check("rnd.pulse", pulse, m_pulse);
                check("rnd.level", level, m_level);
                c++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
Conditions a raw, asynchronous, bouncing push-button into a clean single-cycle count pulse for the 1-digit BCD counter's count input `x`. The block is the stage directly upstream of the counter, and its `pulse` output wires straight to that input. It provides a 2-FF synchronizer, a debounce state machine and a debounced level output.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples of a stable level required to accept a press or release (>=1)
CNT_W, 8, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
REPEAT_DELAY, 8, cycles from the press pulse to the first auto-repeat pulse (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 4, cycles between later auto-repeat pulses (AUTO_REPEAT_EN only)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-low reset
btn_in  input  1  raw button, active-high, asynchronous, may bounce
pulse  output  1  one-cycle count strobe, registered; drives the counter's `x` input
level  output  1  debounced button state, registered

Behaviour:
- Reset (reset==0 at a rising edge) has priority over every other event.
  - sync FFs=0, state=IDLE, deb_cnt=0, rep_cnt=0, pulse=0, level=0.
  - Reset mid-operation discards any pending press; no pulse is emitted for it.
- Synchronizer: s1<=btn_in; s2<=s1. Only s2 feeds the FSM.
- States: IDLE, PRESS_CHK, HELD, REL_CHK. deb_cnt width is CNT_W.
  - IDLE: if s2==1, go to PRESS_CHK with deb_cnt=0.
  - PRESS_CHK:
    - s2==0: go to IDLE (bounce rejected).
    - s2==1 and deb_cnt==DEBOUNCE_CYCLES-1: go to HELD, pulse<=1, level<=1.
    - otherwise: deb_cnt++.
  - HELD: if s2==0, go to REL_CHK with deb_cnt=0.
  - REL_CHK:
    - s2==1: go to HELD (release bounce); no pulse.
    - s2==0 and deb_cnt==DEBOUNCE_CYCLES-1: go to IDLE, level<=0.
    - otherwise: deb_cnt++.
- pulse defaults to 0 every cycle unless set above, so it is never high for two consecutive cycles in the base build.
- Latency, counting rising edges from the first edge at which btn_in is sampled high (edge 1) with btn_in held high:
  - pulse and level rise after edge DEBOUNCE_CYCLES+3.
  - With btn_in held low, level falls after edge DEBOUNCE_CYCLES+3 counted from the first low sample.
- One pulse per accepted press, regardless of hold length (base build).
- Counters never wrap: deb_cnt stops at DEBOUNCE_CYCLES-1 because the FSM changes state there.

Optional Feature:
Macro: BTN_PULSE_GEN_AUTO_REPEAT_EN
- Defined:
  - rep_cnt clears on entry to HELD and increments each cycle in HELD.
  - The first repeat pulse comes REPEAT_DELAY cycles after the press pulse; later repeat pulses come every REPEAT_PERIOD cycles.
  - rep_cnt clears on leaving HELD. Re-entering HELD from REL_CHK restarts the delay and produces no immediate pulse.
- Undefined: rep_cnt and its logic are absent; behaviour is exactly the base FSM.

Decomposition:
- A shared include header (the codebase's package) holds the state encodings `ST_IDLE`=2'd0, `ST_PRESS_CHK`=2'd1, `ST_HELD`=2'd2, `ST_REL_CHK`=2'd3 and the default parameter constants.
- One natural sub-module: sync2, a 1-bit two-flop synchronizer with the same clk/reset. Everything else stays in btn_pulse_gen.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and a 10 ns clock.
1. Reset: reset=0 for 3 edges with btn_in=1 -> pulse=0, level=0 throughout. After reset=1, pulse is high for exactly 1 cycle following edge 7 (counting from the first post-reset edge).
2. Clean press: btn_in=1 for 20 cycles, then 0 -> exactly one pulse; level=1 from edge 7 and returns to 0 7 edges after btn_in falls.
3. Press bounce: btn_in 1,1,0,1,0 then 0 -> no pulse, level stays 0, FSM returns to IDLE.
4. Release bounce: while HELD, btn_in=0 for 2 cycles then 1 -> level stays 1, no additional pulse.
5. Reset during PRESS_CHK: reset=0 at edge 5 of a press -> no pulse; a fresh stable press afterwards produces one pulse with full latency.
6. With the macro defined, REPEAT_DELAY=8, REPEAT_PERIOD=4, btn_in held for 30 cycles -> pulses after edges 7, 15, 19, 23, 27, 31, each 1 cycle wide.
